// File: rtl/v30mz_mem_pkg.sv
// rtl/v30mz_mem_pkg.sv - shared types and constants for the memory access sequencer
package v30mz_mem_pkg;

    localparam int PADDR_W = 20;

    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        DONE
    } mem_seq_state_t;

endpackage

// File: rtl/mem_lane_steer.sv
// rtl/mem_lane_steer.sv - byte-lane mapping for one bus access of a request
module mem_lane_steer
    import v30mz_mem_pkg::*;
(
    input  logic        addr_lsb,
    input  logic        word,
    input  logic        phase,
    input  logic [15:0] wdata,
    output logic [1:0]  be,
    output logic [15:0] lane_wdata,
    output logic        lo_en,
    output logic        lo_from_hi,
    output logic        hi_en,
    output logic        hi_from_hi
);

    always_comb begin
        be         = BE_LO;
        lane_wdata = {wdata[7:0], wdata[7:0]};
        lo_en      = 1'b0;
        lo_from_hi = 1'b0;
        hi_en      = 1'b0;
        hi_from_hi = 1'b0;
        if (word && addr_lsb) begin
            // Odd word: first access carries the low byte on the high lane, second the high byte on the low lane.
            if (!phase) begin
                be         = BE_HI;
                lo_en      = 1'b1;
                lo_from_hi = 1'b1;
            end else begin
                be         = BE_LO;
                lane_wdata = {wdata[15:8], wdata[15:8]};
                hi_en      = 1'b1;
            end
        end else if (word) begin
            be         = BE_WORD;
            lane_wdata = wdata;
            lo_en      = 1'b1;
            hi_en      = 1'b1;
            hi_from_hi = 1'b1;
        end else if (addr_lsb) begin
            be         = BE_HI;
            lo_en      = 1'b1;
            lo_from_hi = 1'b1;
        end else begin
            be    = BE_LO;
            lo_en = 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - runs 16-bit bus cycles for byte/word requests, splitting odd words
module mem_access_sequencer
    import v30mz_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [PADDR_W-1:0] req_addr,
    input  logic               req_word,
    input  logic               req_write,
    input  logic [15:0]        req_wdata,
    output logic               resp_valid,
    output logic [15:0]        resp_rdata,
    output logic [PADDR_W-1:0] bus_addr,
    output logic               bus_rd,
    output logic               bus_wr,
    output logic [1:0]         bus_be,
    output logic [15:0]        bus_wdata,
    input  logic [15:0]        bus_rdata,
    input  logic               bus_ready
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(WAIT_CYCLES);

    mem_seq_state_t state, state_nxt;

    logic [PADDR_W-1:0] lat_addr;
    logic               lat_word;
    logic               lat_write;
    logic [15:0]        lat_wdata;
    logic [CW-1:0]      wait_cnt;
    logic [15:0]        rdata_acc;
    logic               sel_lo_en, sel_lo_from_hi, sel_hi_en, sel_hi_from_hi;

    logic        in_idle, in_acc, accept, complete, split;
    logic [1:0]  st_be;
    logic [15:0] st_wdata;
    logic        st_lo_en, st_lo_from_hi, st_hi_en, st_hi_from_hi;

    assign in_idle  = (state == IDLE);
    assign in_acc   = (state == ACC1) || (state == ACC2);
    assign accept   = in_idle && req_valid;
    assign complete = in_acc && bus_ready && (wait_cnt == '0);
    assign split    = lat_word && lat_addr[0];

    assign req_ready  = in_idle;
    assign resp_valid = (state == DONE);
    assign resp_rdata = rdata_acc;
    assign bus_rd     = in_acc && !lat_write;
    assign bus_wr     = in_acc && lat_write;

    // In IDLE the steer sees the incoming request (first access); otherwise the latched one (second access).
    mem_lane_steer u_steer (
        .addr_lsb   (in_idle ? req_addr[0] : lat_addr[0]),
        .word       (in_idle ? req_word    : lat_word),
        .phase      (!in_idle),
        .wdata      (in_idle ? req_wdata   : lat_wdata),
        .be         (st_be),
        .lane_wdata (st_wdata),
        .lo_en      (st_lo_en),
        .lo_from_hi (st_lo_from_hi),
        .hi_en      (st_hi_en),
        .hi_from_hi (st_hi_from_hi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lat_addr       <= '0;
            lat_word       <= 1'b0;
            lat_write      <= 1'b0;
            lat_wdata      <= '0;
            wait_cnt       <= '0;
            rdata_acc      <= '0;
            bus_addr       <= '0;
            bus_be         <= '0;
            bus_wdata      <= '0;
            sel_lo_en      <= 1'b0;
            sel_lo_from_hi <= 1'b0;
            sel_hi_en      <= 1'b0;
            sel_hi_from_hi <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_addr       <= req_addr;
                lat_word       <= req_word;
                lat_write      <= req_write;
                lat_wdata      <= req_wdata;
                bus_addr       <= req_addr;
                bus_be         <= st_be;
                bus_wdata      <= st_wdata;
                sel_lo_en      <= st_lo_en;
                sel_lo_from_hi <= st_lo_from_hi;
                sel_hi_en      <= st_hi_en;
                sel_hi_from_hi <= st_hi_from_hi;
                wait_cnt       <= WAIT_INIT;
                rdata_acc      <= '0;
            end else if (complete) begin
                if (!lat_write) begin
                    if (sel_lo_en)
                        rdata_acc[7:0] <= sel_lo_from_hi ? bus_rdata[15:8] : bus_rdata[7:0];
                    if (sel_hi_en)
                        rdata_acc[15:8] <= sel_hi_from_hi ? bus_rdata[15:8] : bus_rdata[7:0];
                end
                if (state == ACC1 && split) begin
                    bus_addr       <= lat_addr + 20'd1;
                    bus_be         <= st_be;
                    bus_wdata      <= st_wdata;
                    sel_lo_en      <= st_lo_en;
                    sel_lo_from_hi <= st_lo_from_hi;
                    sel_hi_en      <= st_hi_en;
                    sel_hi_from_hi <= st_hi_from_hi;
                    wait_cnt       <= WAIT_INIT;
                end
            end else if (in_acc && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ACC1;
            ACC1:    if (complete)  state_nxt = split ? ACC2 : DONE;
            ACC2:    if (complete)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for mem_access_sequencer
module tb_mem_access_sequencer;

    typedef struct {
        logic [19:0] addr;
        logic [1:0]  be;
        logic        wr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } bus_exp_t;

    typedef struct {
        logic [15:0] rdata;
        int          t0;
        int          lat;
    } resp_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_valid2 = 1'b0;
    logic [19:0] req_addr = '0;
    logic        req_word = 1'b0, req_write = 1'b0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, resp_valid, bus_rd, bus_wr;
    logic [15:0] resp_rdata, bus_wdata;
    logic [19:0] bus_addr;
    logic [1:0]  bus_be;
    logic [15:0] bus_rdata = '0;
    logic        req_ready2, resp_valid2, bus_rd2, bus_wr2;
    logic [15:0] resp_rdata2, bus_wdata2;
    logic [19:0] bus_addr2;
    logic [1:0]  bus_be2;
    logic        bus_ready2 = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    bus_exp_t  bq[$];
    resp_exp_t rq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_sequencer #(.WAIT_CYCLES(0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_word(req_word), .req_write(req_write), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .bus_addr(bus_addr),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(1'b1)
    );

    mem_access_sequencer #(.WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_addr(req_addr), .req_word(req_word), .req_write(req_write), .req_wdata(req_wdata),
        .resp_valid(resp_valid2), .resp_rdata(resp_rdata2), .bus_addr(bus_addr2),
        .bus_rd(bus_rd2), .bus_wr(bus_wr2), .bus_be(bus_be2), .bus_wdata(bus_wdata2),
        .bus_rdata(16'hCAFE), .bus_ready(bus_ready2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus responder: each strobe cycle is one complete access on the zero-wait instance.
    always @(negedge clk) begin
        if (!reset && (bus_rd || bus_wr)) begin
            check("req_ready_busy", req_ready, 1'b0);
            if (bq.size() == 0) begin
                check("bus_unexpected", 1'b1, 1'b0);
            end else begin
                bus_exp_t e;
                e = bq.pop_front();
                check("bus_addr", bus_addr, e.addr);
                check("bus_be", bus_be, e.be);
                check("bus_wr", bus_wr, e.wr);
                if (e.wr) check("bus_wdata", bus_wdata, e.wdata);
                bus_rdata = e.rdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (rq.size() == 0) begin
                check("resp_spurious", 1'b1, 1'b0);
            end else begin
                resp_exp_t r;
                r = rq.pop_front();
                check("resp_rdata", resp_rdata, r.rdata);
                check("resp_latency", cyc - r.t0, r.lat);
            end
        end
    end

    task automatic push_bus(input logic [19:0] a, input logic [1:0] be, input logic wr,
                            input logic [15:0] wd, input logic [15:0] rd);
        bus_exp_t b;
        b.addr = a; b.be = be; b.wr = wr; b.wdata = wd; b.rdata = rd;
        bq.push_back(b);
    endtask

    // Expected bus accesses and response derived from address, size and direction.
    task automatic push_expect(input logic [19:0] a, input logic w, input logic wr,
                               input logic [15:0] wd, input logic [15:0] r1, input logic [15:0] r2,
                               input logic with_resp);
        resp_exp_t r;
        r.t0 = cyc;
        if (w && a[0]) begin
            push_bus(a, 2'b10, wr, {wd[7:0], wd[7:0]}, r1);
            push_bus(a + 20'd1, 2'b01, wr, {wd[15:8], wd[15:8]}, r2);
            r.rdata = wr ? 16'h0000 : {r2[7:0], r1[15:8]};
            r.lat = 3;
        end else begin
            push_bus(a, w ? 2'b11 : (a[0] ? 2'b10 : 2'b01), wr,
                     w ? wd : {wd[7:0], wd[7:0]}, r1);
            r.rdata = wr ? 16'h0000 : (w ? r1 : (a[0] ? {8'h00, r1[15:8]} : {8'h00, r1[7:0]}));
            r.lat = 2;
        end
        if (with_resp) rq.push_back(r);
    endtask

    task automatic drive_req(input logic [19:0] a, input logic w, input logic wr, input logic [15:0] wd);
        req_valid = 1'b1; req_addr = a; req_word = w; req_write = wr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr = 20'($urandom); req_word = 1'($urandom); req_write = 1'($urandom);
        req_wdata = 16'($urandom);
    endtask

    task automatic issue(input logic [19:0] a, input logic w, input logic wr, input logic [15:0] wd,
                         input logic [15:0] r1, input logic [15:0] r2);
        int i;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        push_expect(a, w, wr, wd, r1, r2, 1'b1);
        drive_req(a, w, wr, wd);
        i = 0;
        while (rq.size() != 0 && i < 20) begin
            @(negedge clk); #1;
            i++;
        end
        if (rq.size() != 0) begin
            check("resp_timeout", 1'b0, 1'b1);
            rq.delete();
        end
        check("bus_all_used", bq.size(), 0);
        bq.delete();
    endtask

    initial begin
        int n, pulses, unstable, found;
        logic [19:0] a0;
        logic [1:0]  be0;
        logic [15:0] got2;

        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 16'h0);
        check("rst_strobes", {bus_rd, bus_wr}, 2'b00);
        check("rst_bus_be", bus_be, 2'b00);
        check("rst_bus_addr", bus_addr, 20'h0);
        check("rst_bus_wdata", bus_wdata, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        issue(20'h12345, 1'b0, 1'b0, 16'h0000, 16'hAB00, 16'h0000);
        issue(20'h01000, 1'b1, 1'b1, 16'hBEEF, 16'h0000, 16'h0000);
        issue(20'hFFFFF, 1'b1, 1'b0, 16'h0000, 16'h3400, 16'h0012);
        issue(20'h00011, 1'b1, 1'b1, 16'h5678, 16'h0000, 16'h0000);
        issue(20'h00400, 1'b0, 1'b1, 16'h995A, 16'h0000, 16'h0000);
        issue(20'h00402, 1'b0, 1'b0, 16'h0000, 16'h77C3, 16'h0000);
        issue(20'h00500, 1'b1, 1'b0, 16'h0000, 16'h9A8B, 16'h0000);
        for (int k = 0; k < 10; k++)
            issue(20'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom));

        // Wait-state instance: 2 wait cycles then bus_ready low for 3 more.
        @(negedge clk);
        req_valid2 = 1'b1; req_addr = 20'h00100; req_word = 1'b1; req_write = 1'b0;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        n = 0; pulses = 0; unstable = 0; a0 = '0; be0 = '0; got2 = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus_rd2 || bus_wr2) begin
                n++;
                if (n == 1) begin
                    a0 = bus_addr2; be0 = bus_be2;
                end else if (bus_addr2 !== a0 || bus_be2 !== be0) begin
                    unstable++;
                end
                bus_ready2 = (n >= 6);
            end
            if (resp_valid2) begin
                pulses++;
                got2 = resp_rdata2;
            end
        end
        bus_ready2 = 1'b0;
        check("w2_strobe_cycles", n, 6);
        check("w2_addr_stable", unstable, 0);
        check("w2_addr", a0, 20'h00100);
        check("w2_be", be0, 2'b11);
        check("w2_resp_pulses", pulses, 1);
        check("w2_rdata", got2, 16'hCAFE);

        // Reset during the second access of a split read.
        @(negedge clk);
        push_expect(20'h00021, 1'b1, 1'b0, 16'h0000, 16'h1100, 16'h2222, 1'b0);
        drive_req(20'h00021, 1'b1, 1'b0, 16'h0000);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk); #1;
            if (bus_rd && bus_addr == 20'h00022) found = 1;
        end
        check("abort_reached_acc2", found, 1);
        reset = 1'b1;
        #1;
        check("abort_strobes", {bus_rd, bus_wr}, 2'b00);
        check("abort_resp_valid", resp_valid, 1'b0);
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_bus_be", bus_be, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        check("abort_bus_used", bq.size(), 0);
        bq.delete();
        repeat (2) @(negedge clk);
        check("post_abort_ready", req_ready, 1'b1);
        issue(20'h00030, 1'b1, 1'b0, 16'h0000, 16'h4D3C, 16'h0000);
        issue(20'h00033, 1'b1, 1'b0, 16'h0000, 16'h6600, 16'h0077);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
